camera_sccb_target: RTL and testbench
=====================================

// Module: camera_sccb_target
// PURPOSE
//  SCCB/I2C responder modelling the camera's register port: the far end of the bus driven by the camera
//  register writer. Decodes device address, 16-bit register address and data bytes. Stores written bytes in a
//  small register memory, answers reads from it, and reports each write as a one-cycle event. Serves as a
//  loopback target on the board and as the camera model in benches.
// PARAMETERS
//  DEV_ADDR  7'h3C  7-bit bus address this target ACKs
//  MEM_AW    8      memory address bits; register address bits [MEM_AW-1:0] index 2**MEM_AW bytes
// PORTS
//  clk_camera      in   1   sole clock; all logic on posedge
//  sys_rst_camera  in   1   asynchronous, active-high reset
//  scl_i           in   1   bus clock as seen at the pad
//  sda_i           in   1   bus data as seen at the pad
//  sda_o           out  1   tied 0 (open-drain)
//  sda_t           out  1   1 = release SDA, 0 = pull SDA low
//  wr_valid        out  1   one-cycle pulse per data byte written
//  wr_addr         out  16  register address of that write; held until the next write
//  wr_data         out  8   data byte of that write; held until the next write
//  busy            out  1   high from an address-matched device byte until STOP/NACK/reset
// BEHAVIOUR
//  - Reset values: sda_t=1, sda_o=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, reg_addr=0, state IDLE.
//    Memory is not reset and powers up zero. Reset mid-transfer releases SDA at once. The target then
//    ignores the bus until the next START.
//  - scl_i and sda_i each pass through a 2-flop synchroniser, then edge detection. SCL high and low phases
//    are each at least 4 clk_camera cycles.
//  - START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognised in every state
//    and take priority over bit handling.
//  - START (incl. repeated) -> DEV; bit counter cleared; reg_addr kept.
//  - STOP -> IDLE; sda_t=1; busy=0.
//  - Bits are sampled on SCL rise, MSB first. SDA is changed only on the cycle after an SCL fall.
//  - States: IDLE, DEV, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO, WDATA, ACK_W, RDATA, MACK, IGNORE.
//  - DEV: 8 bits = {addr[6:0], rw}.
//    - addr == DEV_ADDR: ACK, busy=1. rw=0 -> REG_HI. rw=1 -> preload mem[reg_addr] -> RDATA.
//    - Mismatch -> IGNORE: no ACK, SDA never driven.
//  - ACK slot: on the SCL fall after bit 8, sda_t=0. On the next SCL fall, sda_t=1.
//  - REG_HI / REG_LO load reg_addr[15:8] / [7:0], each ACKed. Then WDATA.
//  - WDATA, on each complete byte:
//    - mem[reg_addr[MEM_AW-1:0]] <= byte.
//    - wr_valid=1 for the one cycle after the 8th SCL rise, with wr_addr=reg_addr and wr_data=byte.
//    - reg_addr increments, 16-bit wrap 0xFFFF -> 0x0000. Byte is ACKed. Back to WDATA.
//  - RDATA:
//    - Drive the byte's bits via sda_t (bit=0 -> sda_t=0, bit=1 -> sda_t=1). Bit 7 goes out on the SCL fall
//      ending the ACK slot. Later bits follow on later falls.
//    - After bit 0's high phase, the next SCL fall releases SDA -> MACK.
//  - MACK: sample SDA on SCL rise.
//    - 0 -> reg_addr++, load next byte -> RDATA.
//    - 1 (NACK) -> IGNORE, busy=0.
//  - Register-address reads follow the SCCB sequence: write phase with REG_HI/REG_LO only, then repeated
//    START with rw=1. Data comes from the kept reg_addr.
//  - START or STOP arriving mid-byte aborts that byte: no memory write, no wr_valid.
//  - A partially received REG_HI/REG_LO leaves reg_addr at its last fully loaded value.
//  - Writes with reg_addr above 2**MEM_AW-1 alias onto the low bits; wr_addr still reports the full 16 bits.
// TESTING
//  1. START, 0x78, 0x35, 0x01, 0x0A, 0x0B, STOP.
//     -> ACK on all 5 bytes. wr_valid pulses twice: (0x3501,0x0A) then (0x3502,0x0B). busy=0 after STOP.
//  2. After test 1: START, 0x78, 0x35, 0x01, repeated START, 0x79, read 2 bytes (master ACK then NACK), STOP.
//     -> SDA carries 0x0A then 0x0B. No wr_valid. Target releases SDA after the NACK.
//  3. START, 0x7A (wrong address), 3 bytes, STOP.
//     -> sda_t stays 1 throughout. busy=0. No wr_valid. Memory unchanged.
//  4. Write to 0xFFFF with data 0x11 then 0x22.
//     -> wr_addr 0xFFFF then 0x0000. mem[0xFF]=0x11, mem[0x00]=0x22.
//  5. STOP after 4 bits of a data byte.
//     -> no wr_valid, IDLE, sda_t=1. A following full write works normally.
//  6. Assert sys_rst_camera while target drives a 0 bit in RDATA.
//     -> sda_t=1 in the same cycle. Bus ignored until a new START; the next transaction is ACKed.

Source files
------------

// File: rtl/camera_sccb_target.sv
// camera_sccb_target
// SCCB/I2C responder that models the camera's register port. It decodes the
// device address, a 16-bit register address and data bytes. It stores written
// bytes in a small register memory, answers reads from that memory, and reports
// each written byte as a one-cycle event.
//
// Ports
//   clk_camera      in   sole clock, all logic on posedge
//   sys_rst_camera  in   asynchronous active-high reset
//   scl_i / sda_i   in   bus clock / data as seen at the pad
//   sda_o           out  constant 0 (open-drain data value)
//   sda_t           out  1 = release SDA, 0 = pull SDA low
//   wr_valid        out  one-cycle pulse per data byte written
//   wr_addr[15:0]   out  register address of the last write
//   wr_data[7:0]    out  data byte of the last write
//   busy            out  high from an address-matched device byte until STOP/NACK/reset
module camera_sccb_target #(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int          MEM_AW  = 8
) (
    input  logic        clk_camera,
    input  logic        sys_rst_camera,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO,
        WDATA, ACK_W, RDATA, MACK, IGNORE
    } state_t;

    state_t      state;
    logic        scl_meta, scl_sync, scl_prev;
    logic        sda_meta, sda_sync, sda_prev;
    logic [2:0]  bit_cnt;
    logic [6:0]  shift;
    logic [7:0]  tx;
    logic [15:0] reg_addr;
    logic        is_read;
    // In ACK slots: set once SDA is pulled low. In MACK: set once the master ACKed.
    logic        slot_half;

    logic [7:0]  mem [0:(1 << MEM_AW) - 1];

    logic        scl_rise, scl_fall, start_det, stop_det, mem_we;
    logic [7:0]  rx_byte, rd_now, rd_next;
    logic [15:0] rd_next_addr;

    assign sda_o = 1'b0;

    // Two-flop synchronisers plus one delay stage for edge detection. Reset to
    // the idle bus level so that coming out of reset does not look like an edge.
    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_prev <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_meta <= scl_i;
            scl_sync <= scl_meta;
            scl_prev <= scl_sync;
            sda_meta <= sda_i;
            sda_sync <= sda_meta;
            sda_prev <= sda_sync;
        end
    end

    // START/STOP need SCL high on both samples, so neither can coincide with an SCL edge.
    assign scl_rise     = scl_sync & ~scl_prev;
    assign scl_fall     = ~scl_sync & scl_prev;
    assign start_det    = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign stop_det     = scl_sync & scl_prev & ~sda_prev & sda_sync;
    assign rx_byte      = {shift, sda_sync};
    assign rd_next_addr = reg_addr + 16'd1;
    assign rd_now       = mem[reg_addr[MEM_AW-1:0]];
    assign rd_next      = mem[rd_next_addr[MEM_AW-1:0]];
    assign mem_we       = scl_rise && (state == WDATA) && (bit_cnt == 3'd7);

    // Register memory. It has no reset so that it maps onto block RAM.
    // Addresses above the memory size alias onto the low bits.
    always_ff @(posedge clk_camera) begin
        if (mem_we) begin
            mem[reg_addr[MEM_AW-1:0]] <= rx_byte;
        end
    end

    // Protocol FSM. START/STOP take priority over bit handling in every state.
    // Bits are sampled on SCL rise. SDA is only changed in response to an SCL fall.
    always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
        if (sys_rst_camera) begin
            state     <= IDLE;
            sda_t     <= 1'b1;
            wr_valid  <= 1'b0;
            wr_addr   <= 16'h0000;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            reg_addr  <= 16'h0000;
            bit_cnt   <= 3'd0;
            shift     <= 7'h00;
            tx        <= 8'h00;
            is_read   <= 1'b0;
            slot_half <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            if (start_det) begin
                state     <= DEV;
                bit_cnt   <= 3'd0;
                sda_t     <= 1'b1;
                slot_half <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                bit_cnt   <= 3'd0;
                sda_t     <= 1'b1;
                slot_half <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    DEV, REG_HI, REG_LO, WDATA: begin
                        if (scl_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                slot_half <= 1'b0;
                                case (state)
                                    DEV: begin
                                        if (rx_byte[7:1] == DEV_ADDR) begin
                                            busy    <= 1'b1;
                                            is_read <= rx_byte[0];
                                            tx      <= rd_now;
                                            state   <= ACK_DEV;
                                        end else begin
                                            state <= IGNORE;
                                        end
                                    end
                                    REG_HI: begin
                                        reg_addr[15:8] <= rx_byte;
                                        state          <= ACK_HI;
                                    end
                                    REG_LO: begin
                                        reg_addr[7:0] <= rx_byte;
                                        state         <= ACK_LO;
                                    end
                                    default: begin
                                        wr_valid <= 1'b1;
                                        wr_addr  <= reg_addr;
                                        wr_data  <= rx_byte;
                                        reg_addr <= rd_next_addr;
                                        state    <= ACK_W;
                                    end
                                endcase
                            end
                        end
                    end
                    ACK_DEV, ACK_HI, ACK_LO, ACK_W: begin
                        if (scl_fall) begin
                            if (!slot_half) begin
                                sda_t     <= 1'b0;
                                slot_half <= 1'b1;
                            end else begin
                                slot_half <= 1'b0;
                                sda_t     <= 1'b1;
                                case (state)
                                    ACK_DEV: begin
                                        if (is_read) begin
                                            // The fall ending the ACK slot also puts out bit 7.
                                            sda_t <= tx[7];
                                            tx    <= {tx[6:0], 1'b0};
                                            state <= RDATA;
                                        end else begin
                                            state <= REG_HI;
                                        end
                                    end
                                    ACK_HI:  state <= REG_LO;
                                    default: state <= WDATA;
                                endcase
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_t     <= 1'b1;
                                bit_cnt   <= 3'd0;
                                slot_half <= 1'b0;
                                state     <= MACK;
                            end else begin
                                sda_t   <= tx[7];
                                tx      <= {tx[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    MACK: begin
                        if (scl_rise) begin
                            if (!sda_sync) begin
                                reg_addr  <= rd_next_addr;
                                tx        <= rd_next;
                                slot_half <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= IGNORE;
                            end
                        end else if (scl_fall && slot_half) begin
                            slot_half <= 1'b0;
                            sda_t     <= tx[7];
                            tx        <= {tx[6:0], 1'b0};
                            bit_cnt   <= 3'd0;
                            state     <= RDATA;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_sccb_target.sv
// tb_camera_sccb_target
// Directed bench for camera_sccb_target. A behavioural bus master drives SCL and
// SDA. The bus is modelled as a wired-AND of the master and the target pad.
// Expected values are hand-computed constants.
module tb_camera_sccb_target;

    localparam int H = 8;

    logic        clk_camera = 1'b0;
    logic        sys_rst_camera;
    logic        master_scl;
    logic        master_sda;
    logic        scl_i, sda_i, sda_o, sda_t, wr_valid, busy;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    int vectors     = 0;
    int miscompares = 0;
    int sda_low_cnt = 0;

    logic [15:0] ev_addr [$];
    logic [7:0]  ev_data [$];

    always #5 clk_camera = ~clk_camera;

    assign scl_i = master_scl;
    assign sda_i = master_sda & (sda_t ? 1'b1 : sda_o);

    camera_sccb_target dut (
        .clk_camera     (clk_camera),
        .sys_rst_camera (sys_rst_camera),
        .scl_i          (scl_i),
        .sda_i          (sda_i),
        .sda_o          (sda_o),
        .sda_t          (sda_t),
        .wr_valid       (wr_valid),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy)
    );

    // Record every write event and count cycles in which the target pulls SDA low.
    always @(negedge clk_camera) begin
        if (wr_valid) begin
            ev_addr.push_back(wr_addr);
            ev_data.push_back(wr_data);
        end
        if (sda_t == 1'b0) begin
            sda_low_cnt++;
        end
    end

    // Safety net: stop the run if the bench itself ever stalls.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_camera);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] miscompare on %s", tag);
        end
    endtask

    task automatic check_event(input int idx, input logic [15:0] a, input logic [7:0] d, input string tag);
        logic [15:0] oa;
        logic [7:0]  od;
        oa = 16'hxxxx;
        od = 8'hxx;
        if (idx < ev_addr.size()) begin
            oa = ev_addr[idx];
            od = ev_data[idx];
        end
        check_output({tag, "_addr"}, {16'h0, oa}, {16'h0, a});
        check_output({tag, "_data"}, {24'h0, od}, {24'h0, d});
    endtask

    task automatic bus_start();
        wait_cyc(H/2); master_sda = 1'b1;
        wait_cyc(H/2); master_scl = 1'b1;
        wait_cyc(H);   master_sda = 1'b0;
        wait_cyc(H);   master_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_cyc(H/2); master_sda = 1'b0;
        wait_cyc(H/2); master_scl = 1'b1;
        wait_cyc(H);   master_sda = 1'b1;
        wait_cyc(H);
    endtask

    task automatic write_bit(input logic b);
        wait_cyc(H/2); master_sda = b;
        wait_cyc(H/2); master_scl = 1'b1;
        wait_cyc(H);   master_scl = 1'b0;
    endtask

    // Send a byte and check the ACK bit seen on the bus (0 = ACK).
    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic ack;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        wait_cyc(H/2); master_sda = 1'b1;
        wait_cyc(H/2); master_scl = 1'b1;
        wait_cyc(H/2); ack = sda_i;
        wait_cyc(H/2); master_scl = 1'b0;
        check_output(tag, {31'h0, ack}, {31'h0, exp_ack});
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        b = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            wait_cyc(H);   master_scl = 1'b1;
            wait_cyc(H/2); b[i] = sda_i;
            wait_cyc(H/2); master_scl = 1'b0;
        end
        wait_cyc(H/2); master_sda = mack;
        wait_cyc(H/2); master_scl = 1'b1;
        wait_cyc(H);   master_scl = 1'b0;
        wait_cyc(H/2); master_sda = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;
        int ev_base;
        int low0;

        sys_rst_camera = 1'b1;
        master_scl     = 1'b1;
        master_sda     = 1'b1;
        wait_cyc(5);
        check_output("rst_sda_t",    {31'h0, sda_t},    32'h1);
        check_output("rst_sda_o",    {31'h0, sda_o},    32'h0);
        check_output("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
        check_output("rst_wr_addr",  {16'h0, wr_addr},  32'h0);
        check_output("rst_wr_data",  {24'h0, wr_data},  32'h0);
        check_output("rst_busy",     {31'h0, busy},     32'h0);
        sys_rst_camera = 1'b0;
        wait_cyc(5);

        // 1: write two bytes at 0x3501
        $display("[TB] step 1: write 0x0A,0x0B to 0x3501");
        ev_base = ev_addr.size();
        bus_start();
        write_byte(8'h78, 1'b0, "t1_ack_dev");
        check_output("t1_busy_hi", {31'h0, busy}, 32'h1);
        write_byte(8'h35, 1'b0, "t1_ack_hi");
        write_byte(8'h01, 1'b0, "t1_ack_lo");
        write_byte(8'h0A, 1'b0, "t1_ack_d0");
        write_byte(8'h0B, 1'b0, "t1_ack_d1");
        bus_stop();
        check_output("t1_busy_lo", {31'h0, busy}, 32'h0);
        check_output("t1_ev_cnt", ev_addr.size() - ev_base, 32'd2);
        check_event(ev_base,     16'h3501, 8'h0A, "t1_ev0");
        check_event(ev_base + 1, 16'h3502, 8'h0B, "t1_ev1");

        // 2: register-address read via repeated START
        $display("[TB] step 2: read back 2 bytes from 0x3501");
        ev_base = ev_addr.size();
        bus_start();
        write_byte(8'h78, 1'b0, "t2_ack_dev");
        write_byte(8'h35, 1'b0, "t2_ack_hi");
        write_byte(8'h01, 1'b0, "t2_ack_lo");
        bus_start();
        write_byte(8'h79, 1'b0, "t2_ack_rd");
        read_byte(1'b0, rb);
        check_output("t2_rd0", {24'h0, rb}, 32'h0A);
        read_byte(1'b1, rb);
        check_output("t2_rd1", {24'h0, rb}, 32'h0B);
        wait_cyc(4);
        check_output("t2_release", {31'h0, sda_t}, 32'h1);
        check_output("t2_busy_nack", {31'h0, busy}, 32'h0);
        bus_stop();
        check_output("t2_no_wr", ev_addr.size() - ev_base, 32'd0);

        // 3: wrong device address is ignored
        $display("[TB] step 3: foreign address 0x7A");
        ev_base = ev_addr.size();
        low0    = sda_low_cnt;
        bus_start();
        write_byte(8'h7A, 1'b1, "t3_nack_dev");
        write_byte(8'h35, 1'b1, "t3_nack_b0");
        write_byte(8'h01, 1'b1, "t3_nack_b1");
        write_byte(8'hEE, 1'b1, "t3_nack_b2");
        bus_stop();
        check_output("t3_sda_low", sda_low_cnt - low0, 32'd0);
        check_output("t3_busy", {31'h0, busy}, 32'h0);
        check_output("t3_no_wr", ev_addr.size() - ev_base, 32'd0);
        bus_start();
        write_byte(8'h78, 1'b0, "t3_ack_dev");
        write_byte(8'h35, 1'b0, "t3_ack_hi");
        write_byte(8'h01, 1'b0, "t3_ack_lo");
        bus_start();
        write_byte(8'h79, 1'b0, "t3_ack_rd");
        read_byte(1'b1, rb);
        check_output("t3_mem_kept", {24'h0, rb}, 32'h0A);
        bus_stop();

        // 4: address wrap 0xFFFF -> 0x0000 and aliasing onto the memory
        $display("[TB] step 4: write across 0xFFFF");
        ev_base = ev_addr.size();
        bus_start();
        write_byte(8'h78, 1'b0, "t4_ack_dev");
        write_byte(8'hFF, 1'b0, "t4_ack_hi");
        write_byte(8'hFF, 1'b0, "t4_ack_lo");
        write_byte(8'h11, 1'b0, "t4_ack_d0");
        write_byte(8'h22, 1'b0, "t4_ack_d1");
        bus_stop();
        check_output("t4_ev_cnt", ev_addr.size() - ev_base, 32'd2);
        check_event(ev_base,     16'hFFFF, 8'h11, "t4_ev0");
        check_event(ev_base + 1, 16'h0000, 8'h22, "t4_ev1");
        bus_start();
        write_byte(8'h78, 1'b0, "t4_rack_dev");
        write_byte(8'h00, 1'b0, "t4_rack_hi");
        write_byte(8'hFF, 1'b0, "t4_rack_lo");
        bus_start();
        write_byte(8'h79, 1'b0, "t4_ack_rd");
        read_byte(1'b0, rb);
        check_output("t4_mem_ff", {24'h0, rb}, 32'h11);
        read_byte(1'b1, rb);
        check_output("t4_mem_00", {24'h0, rb}, 32'h22);
        bus_stop();

        // 5: STOP in the middle of a data byte
        $display("[TB] step 5: abort data byte after 4 bits");
        ev_base = ev_addr.size();
        bus_start();
        write_byte(8'h78, 1'b0, "t5_ack_dev");
        write_byte(8'h12, 1'b0, "t5_ack_hi");
        write_byte(8'h34, 1'b0, "t5_ack_lo");
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        bus_stop();
        check_output("t5_no_wr", ev_addr.size() - ev_base, 32'd0);
        check_output("t5_busy", {31'h0, busy}, 32'h0);
        check_output("t5_sda_t", {31'h0, sda_t}, 32'h1);
        bus_start();
        write_byte(8'h78, 1'b0, "t5_ack_dev2");
        write_byte(8'h12, 1'b0, "t5_ack_hi2");
        write_byte(8'h34, 1'b0, "t5_ack_lo2");
        write_byte(8'h5A, 1'b0, "t5_ack_d");
        bus_stop();
        check_output("t5_ev_cnt", ev_addr.size() - ev_base, 32'd1);
        check_event(ev_base, 16'h1234, 8'h5A, "t5_ev");

        // 6: reset while the target drives a 0 data bit
        $display("[TB] step 6: reset during read");
        bus_start();
        write_byte(8'h78, 1'b0, "t6_ack_dev");
        write_byte(8'h35, 1'b0, "t6_ack_hi");
        write_byte(8'h01, 1'b0, "t6_ack_lo");
        bus_start();
        write_byte(8'h79, 1'b0, "t6_ack_rd");
        wait_cyc(6);
        check_output("t6_drive0", {31'h0, sda_t}, 32'h0);
        sys_rst_camera = 1'b1;
        #1;
        check_output("t6_rst_release", {31'h0, sda_t}, 32'h1);
        check_output("t6_rst_busy", {31'h0, busy}, 32'h0);
        check_output("t6_rst_wr_addr", {16'h0, wr_addr}, 32'h0);
        wait_cyc(4);
        sys_rst_camera = 1'b0;
        wait_cyc(4);
        low0 = sda_low_cnt;
        read_byte(1'b1, rb);
        bus_stop();
        check_output("t6_ignored", sda_low_cnt - low0, 32'd0);
        ev_base = ev_addr.size();
        bus_start();
        write_byte(8'h78, 1'b0, "t6_ack_dev2");
        write_byte(8'h00, 1'b0, "t6_ack_hi2");
        write_byte(8'h05, 1'b0, "t6_ack_lo2");
        write_byte(8'h55, 1'b0, "t6_ack_d");
        bus_stop();
        check_output("t6_ev_cnt", ev_addr.size() - ev_base, 32'd1);
        check_event(ev_base, 16'h0005, 8'h55, "t6_ev");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
